fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Downstream consumer of the byte FIFO. It pops one word whenever the FIFO is non-empty and serialises it onto a UART line as 8N1 framing: start bit, DATA_WIDTH data bits LSB first, one stop bit. It drives the FIFO's take strobe directly and connects to the FIFO's empty flag and read-data output with no glue logic. Frames are sent back-to-back with no idle gap while data remains.

Parameters:
DATA_WIDTH, 8, payload bits per frame; must match the FIFO data width.
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is 1 and above.

Ports:
in_clock  input  1  system clock; all state updates on the rising edge.
in_reset  input  1  reset, synchronous, active-low; 0 = reset.
in_fifo_empty  input  1  FIFO empty flag; 1 = no data available.
in_fifo_data  input  DATA_WIDTH  FIFO head word; valid whenever in_fifo_empty = 0.
out_fifo_take  output  1  pop strobe to the FIFO; the FIFO advances on the edge where this is 1.
out_tx  output  1  serial line; idle level is 1.
out_busy  output  1  1 while a frame is in progress (START, DATA or STOP).

Behaviour:
- Reset: in_reset = 0 at a rising edge sets the following. State = IDLE, out_tx = 1, out_busy = 0, baud counter = 0, bit counter = 0, shift register = 0.
- Reset gating: out_fifo_take = 0 in every cycle where in_reset = 0, regardless of in_fifo_empty.
- Reset mid-frame: the frame is aborted and out_tx returns to 1 after the edge. The popped word is discarded. No extra pop occurs.
- FSM states: IDLE, START, DATA, STOP. State is registered. out_tx and out_busy are registered outputs.
- out_fifo_take (combinational from registered state, counters and in_fifo_empty):
  - take = !in_fifo_empty && in_reset && (state == IDLE || (state == STOP && baud_last)).
  - baud_last is 1 when baud counter = CLKS_PER_BIT-1.
  - On any edge where take = 1: capture in_fifo_data into the shift register, then next state = START, out_tx = 0, baud counter = 0.
- IDLE: out_tx = 1 and out_busy = 0. The block stays in IDLE while in_fifo_empty = 1.
- Pop-to-start latency: start bit appears on out_tx one clock after the take cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1, then wraps to 0. Width is clog2(CLKS_PER_BIT), minimum 1 bit. Each state holds for exactly CLKS_PER_BIT cycles per bit.
- START, on baud_last: next state = DATA, out_tx = shift[0], bit counter = 0.
- DATA, on baud_last:
  - If bit counter < DATA_WIDTH-1: shift right, out_tx = next bit, bit counter + 1.
  - Else: next state = STOP, out_tx = 1.
- STOP, on baud_last:
  - If take = 1: go straight to START. Back-to-back frames of exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - Else: next state = IDLE.
- out_busy is 1 in START, DATA and STOP, and 0 in IDLE.
- Empty during a frame: has no effect. in_fifo_data and in_fifo_empty are ignored except in take-eligible cycles.
- Line integrity: out_tx never glitches mid-bit. It changes only on bit boundaries or on reset.
- CLKS_PER_BIT = 1: every cycle is baud_last, so one bit per clock. A frame is DATA_WIDTH+2 cycles and pops are DATA_WIDTH+2 cycles apart.

Decomposition:
- Shared header uart_defs.v holds:
  - state encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the default CLKS_PER_BIT.
- One sub-module, uart_baud_counter: parameter CLKS_PER_BIT; ports in_clock, in_reset, in_clear, out_last.
  - It provides the per-bit counter and the baud_last flag.
  - in_clear is pulsed on take.
- Everything else is the top-level FSM.

Test Plan (all scenarios use CLKS_PER_BIT = 4 and DATA_WIDTH = 8):
- Reset, then FIFO empty for 100 cycles: out_tx = 1, out_busy = 0, out_fifo_take = 0 throughout.
- Single byte 0xA5 made available:
  - out_fifo_take is high for exactly 1 cycle;
  - out_tx then shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - out_busy is high for 40 cycles, then IDLE.
- Bytes 0x01 and 0xFF queued together:
  - the two take pulses are exactly 40 cycles apart;
  - the stop bit of frame 1 is followed directly by the start bit of frame 2 (no idle cycle);
  - out_tx for frame 2 is 0, eight 1s, then 1.
- in_reset driven low at cycle 15 of a 0x00 frame:
  - out_tx = 1 and out_busy = 0 after the edge;
  - no take pulse while reset is low;
  - after release with the FIFO still holding 0x3C, a new full frame for 0x3C is sent.
- in_fifo_empty toggled and in_fifo_data changed mid-frame: the transmitted bits match the captured byte only, and there are no extra take pulses.
- Rebuild with CLKS_PER_BIT = 1 and send 0x80: out_tx = 0,0,0,0,0,0,0,0,1,1 on consecutive cycles.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encodings, defaults and sizing helper for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } tx_state_e;

   localparam int unsigned DefaultDataWidth  = 8;
   localparam int unsigned DefaultClksPerBit = 868;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit cycle counter; out_last marks the final cycle of each UART bit period.
module uart_baud_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
   input  logic in_clock,
   input  logic in_reset,
   input  logic in_clear,
   output logic out_last
);

   localparam int unsigned     CntW    = min1_clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] r_count;

   assign out_last = (r_count == LastCnt);

   always_ff @(posedge in_clock) begin
      if (!in_reset || in_clear || out_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO and serialises them as 8N1 UART frames, back-to-back while data remains.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
   input  logic                  in_clock,
   input  logic                  in_reset,
   input  logic                  in_fifo_empty,
   input  logic [DATA_WIDTH-1:0] in_fifo_data,
   output logic                  out_fifo_take,
   output logic                  out_tx,
   output logic                  out_busy
);

   localparam int unsigned     BitW    = min1_clog2(DATA_WIDTH);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

   tx_state_e             r_state, w_state_d;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
   logic [BitW-1:0]       r_bit_cnt, w_bit_cnt_d;
   logic                  r_tx, w_tx_d;
   logic                  r_busy;
   logic                  w_baud_last;
   logic                  w_take;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .in_clock(in_clock),
      .in_reset(in_reset),
      .in_clear(w_take),
      .out_last(w_baud_last)
   );

   // A stop bit's last cycle may pop the next word so frames abut with no idle gap.
   assign w_take = !in_fifo_empty && in_reset &&
                   (r_state == StIdle || (r_state == StStop && w_baud_last));

   assign out_fifo_take = w_take;
   assign out_tx        = r_tx;
   assign out_busy      = r_busy;

   always_comb begin
      w_state_d   = r_state;
      w_shift_d   = r_shift;
      w_bit_cnt_d = r_bit_cnt;
      w_tx_d      = r_tx;
      if (w_take) begin
         w_shift_d = in_fifo_data;
         w_state_d = StStart;
         w_tx_d    = 1'b0;
      end else if (w_baud_last) begin
         unique case (r_state)
            StIdle: begin
               w_tx_d = 1'b1;
            end
            StStart: begin
               w_state_d   = StData;
               w_tx_d      = r_shift[0];
               w_bit_cnt_d = '0;
            end
            StData: begin
               if (r_bit_cnt < LastBit) begin
                  w_shift_d   = r_shift >> 1;
                  w_tx_d      = w_shift_d[0];
                  w_bit_cnt_d = r_bit_cnt + 1'b1;
               end else begin
                  w_state_d = StStop;
                  w_tx_d    = 1'b1;
               end
            end
            StStop: begin
               w_state_d = StIdle;
               w_tx_d    = 1'b1;
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_shift   <= w_shift_d;
         r_bit_cnt <= w_bit_cnt_d;
         r_tx      <= w_tx_d;
         r_busy    <= (w_state_d != StIdle);
      end
   end

endmodule
